histogram_engine: RTL and testbench
===================================

# histogram_engine

Parametrised, fully pipelined histogram kernel; successor to the fixed 100-pixel, II=2 histogram loop. Streams `len` elements from an input array memory (arg_0), maps each to a bin, and read-modify-write increments the bin in a count memory (arg_1) at one element per cycle (II=1) with same-bin hazard forwarding. Adds an optional clear pass, a run-length input, and optional saturating counts. Sits between the top-level start/valid control and two external synchronous RAMs.

## Interface
Parameters:
- DATA_WIDTH, 8, element width; must be >= BIN_ADDR_WIDTH
- ADDR_WIDTH, 12, arg_0 address width
- BIN_ADDR_WIDTH, 8, arg_1 address width; bin count = 2^BIN_ADDR_WIDTH
- COUNT_WIDTH, 32, bin counter width
- SATURATE, 0, 1 = counts clamp at all-ones; 0 = wrap modulo 2^COUNT_WIDTH

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock, asynchronous, active-high
- start  in  1  begin run; sampled only in IDLE or DONE
- len  in  ADDR_WIDTH+1  element count, sampled with start; 0..2^ADDR_WIDTH
- clear_first  in  1  sampled with start; 1 = zero all bins before counting
- busy  out  1  high in CLEAR, RUN, DRAIN
- valid  out  1  high while in DONE
- arg_0_raddr_0  out  ADDR_WIDTH  element read address
- arg_0_rdata_0  in  DATA_WIDTH  element data, 1-cycle read latency
- arg_1_raddr_0  out  BIN_ADDR_WIDTH  bin read address
- arg_1_rdata_0  in  COUNT_WIDTH  bin data, 1-cycle read latency
- arg_1_waddr_0, arg_1_wdata_0, arg_1_wen_0  out  BIN_ADDR_WIDTH / COUNT_WIDTH / 1  bin write port

## Operation
- States: IDLE -> (start) CLEAR if clear_first else RUN; CLEAR -> RUN after last bin; RUN -> DRAIN after issuing element len-1; DRAIN -> DONE when pipeline empty; DONE -> (start) CLEAR/RUN. len=0 skips RUN/DRAIN (CLEAR still runs if requested).
- start while busy ignored; len/clear_first captured only on accepted start.
- CLEAR: one write per cycle, waddr 0..2^BIN_ADDR_WIDTH-1, wdata 0, wen 1.
- Bin = top BIN_ADDR_WIDTH bits of element (element >> (DATA_WIDTH-BIN_ADDR_WIDTH)).
- Increment: new = old+1; SATURATE=1 and old all-ones -> new = old.
- RAM model: read issued in cycle t returns at t+1 reflecting writes of cycles < t only. Element k-1 writes in the cycle element k's bin read issues, so if bin_k == bin_{k-1} (k-1 valid), old = forwarded write value, not arg_1_rdata_0. Element k-2 needs no forwarding.
- Idle outputs: all addresses 0, wdata 0, wen 0 when not in use.
- arg_1_raddr_0 is combinational from arg_0_rdata_0 (documented path); all other outputs derive from registers plus arg_1_rdata_0.

## Timing
- Reset: state IDLE, busy 0, valid 0, all address/data/wen outputs 0, pipeline valids cleared. Reset mid-run aborts immediately; RAM contents left as-is (partial histogram).
- start accepted at edge E; first CLEAR/RUN cycle is E+1.
- CLEAR occupies 2^BIN_ADDR_WIDTH cycles; RUN cycle r0 is the cycle after the last clear write.
- Element k: arg_0_raddr_0 = k in cycle r0+k; arg_1_raddr_0 = bin in r0+k+1; write (wen=1) in r0+k+2.
- Last write in r0+len+1; valid rises in r0+len+2; busy falls same edge.
- No clear, len=N: valid rises N+2 cycles after first RUN cycle, i.e. E+N+3.
- valid holds until a start is accepted in DONE (falls the next edge).

## Structure
- Shared package: state enum (IDLE, CLEAR, RUN, DRAIN, DONE), bin-slice function, saturating-increment function.
- One natural sub-module: histogram_rmw_stage (bin compare, forwarding mux, increment/saturate, write-port drive); FSM and element counter stay in top.

## Test plan
- Reset mid-RUN at element 37 -> all outputs 0 next cycle, valid 0, no further writes; new start works.
- clear_first=1, len=0, prefilled bins -> 256 zero writes, valid at E+257, all bins 0.
- len=100, elements 0..99, DATA=BIN=8 -> bins 0..99 = 1, rest 0, valid at E+103, one write per cycle.
- len=16, all elements 0x2A -> bin 42 = 16 (forwarding back-to-back); pattern A,B,A,B -> each 2 (no false forwarding).
- DATA_WIDTH=12, BIN_ADDR_WIDTH=4, element 0xFFF -> bin 15; SATURATE=1, COUNT_WIDTH=4, 20 hits -> bin 15 = 15; SATURATE=0 -> 4.
- start pulsed while busy -> ignored; start in DONE -> valid drops next edge, new run begins.

Source files
------------

// File: rtl/histogram_engine_pkg.sv
// Shared types and helpers for the histogram engine: FSM state encoding,
// element-to-bin slicing and the (optionally saturating) counter increment.
package histogram_engine_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLEAR = 3'd1,
      ST_RUN   = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   // Bin index is the top bits of the element; callers size-cast the result.
   function automatic logic [63:0] bin_slice(input logic [63:0] element, input int shift);
      return element >> shift;
   endfunction

   function automatic logic [63:0] sat_increment(input logic [63:0] old,
                                                 input int width,
                                                 input logic saturate);
      logic [63:0] ones;
      ones = (width >= 32'sd64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
      if (saturate && ((old & ones) == ones)) begin
         return old & ones;
      end else begin
         return (old + 64'd1) & ones;
      end
   endfunction

endpackage

// File: rtl/histogram_engine_rmw.sv
// Read-modify-write stage: bin lookup, same-bin forwarding from the previous
// write, increment/saturate and the shared count-memory write port.
module histogram_rmw_stage
   import histogram_engine_pkg::*;
#(
   parameter int DATA_WIDTH     = 8,
   parameter int BIN_ADDR_WIDTH = 8,
   parameter int COUNT_WIDTH    = 32,
   parameter int SATURATE       = 0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      elem_valid,
   input  logic [DATA_WIDTH-1:0]     element,
   input  logic                      clear_en,
   input  logic [BIN_ADDR_WIDTH-1:0] clear_addr,
   input  logic [COUNT_WIDTH-1:0]    rdata,
   output logic [BIN_ADDR_WIDTH-1:0] raddr,
   output logic [BIN_ADDR_WIDTH-1:0] waddr,
   output logic [COUNT_WIDTH-1:0]    wdata,
   output logic                      wen,
   output logic                      wr_pending
);

   logic [BIN_ADDR_WIDTH-1:0] bin_s;
   logic [COUNT_WIDTH-1:0]    old_s;
   logic [COUNT_WIDTH-1:0]    inc_s;
   logic                      wr_valid_r;
   logic [BIN_ADDR_WIDTH-1:0] wr_bin_r;
   logic                      fwd_valid_r;
   logic [BIN_ADDR_WIDTH-1:0] fwd_bin_r;
   logic [COUNT_WIDTH-1:0]    fwd_data_r;

   assign bin_s      = BIN_ADDR_WIDTH'(bin_slice(64'(element), DATA_WIDTH - BIN_ADDR_WIDTH));
   assign raddr      = elem_valid ? bin_s : {BIN_ADDR_WIDTH{1'b0}};
   assign wr_pending = wr_valid_r;

   // The previous element's write lands in the same cycle this bin was read,
   // so the RAM returns a stale count on a back-to-back hit.
   assign old_s = (fwd_valid_r && (fwd_bin_r == wr_bin_r)) ? fwd_data_r : rdata;
   assign inc_s = COUNT_WIDTH'(sat_increment(64'(old_s), COUNT_WIDTH, SATURATE != 0));

   // Pipeline registers: pending write and a one-deep copy of the last write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_valid_r  <= 1'b0;
         wr_bin_r    <= {BIN_ADDR_WIDTH{1'b0}};
         fwd_valid_r <= 1'b0;
         fwd_bin_r   <= {BIN_ADDR_WIDTH{1'b0}};
         fwd_data_r  <= {COUNT_WIDTH{1'b0}};
      end else begin
         wr_valid_r  <= elem_valid;
         wr_bin_r    <= elem_valid ? bin_s : {BIN_ADDR_WIDTH{1'b0}};
         fwd_valid_r <= wr_valid_r;
         fwd_bin_r   <= wr_bin_r;
         fwd_data_r  <= wr_valid_r ? inc_s : {COUNT_WIDTH{1'b0}};
      end
   end

   // Write port: clear pass has priority; otherwise the pending increment.
   always_comb begin
      wen   = 1'b0;
      waddr = {BIN_ADDR_WIDTH{1'b0}};
      wdata = {COUNT_WIDTH{1'b0}};
      if (clear_en) begin
         wen   = 1'b1;
         waddr = clear_addr;
      end else if (wr_valid_r) begin
         wen   = 1'b1;
         waddr = wr_bin_r;
         wdata = inc_s;
      end else begin
         wen   = 1'b0;
      end
   end

endmodule

// File: rtl/histogram_engine.sv
// Pipelined histogram kernel: control FSM, clear counter and element issue;
// the bin read-modify-write lives in histogram_rmw_stage.
module histogram_engine
   import histogram_engine_pkg::*;
#(
   parameter int DATA_WIDTH     = 8,
   parameter int ADDR_WIDTH     = 12,
   parameter int BIN_ADDR_WIDTH = 8,
   parameter int COUNT_WIDTH    = 32,
   parameter int SATURATE       = 0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [ADDR_WIDTH:0]       len,
   input  logic                      clear_first,
   output logic                      busy,
   output logic                      valid,
   output logic [ADDR_WIDTH-1:0]     arg_0_raddr_0,
   input  logic [DATA_WIDTH-1:0]     arg_0_rdata_0,
   output logic [BIN_ADDR_WIDTH-1:0] arg_1_raddr_0,
   input  logic [COUNT_WIDTH-1:0]    arg_1_rdata_0,
   output logic [BIN_ADDR_WIDTH-1:0] arg_1_waddr_0,
   output logic [COUNT_WIDTH-1:0]    arg_1_wdata_0,
   output logic                      arg_1_wen_0
);

   state_t                    state_r, state_next;
   logic [ADDR_WIDTH:0]       len_r;
   logic [ADDR_WIDTH:0]       elem_cnt_r;
   logic [BIN_ADDR_WIDTH-1:0] clear_cnt_r;
   logic                      elem_valid_r;
   logic                      wr_pending_s;
   logic                      last_clear_s;
   logic                      last_elem_s;
   logic                      start_ok_s;

   assign start_ok_s   = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
   assign last_clear_s = (clear_cnt_r == {BIN_ADDR_WIDTH{1'b1}});
   assign last_elem_s  = (elem_cnt_r == (len_r - {{ADDR_WIDTH{1'b0}}, 1'b1}));

   assign busy          = (state_r == ST_CLEAR) || (state_r == ST_RUN) || (state_r == ST_DRAIN);
   assign valid         = (state_r == ST_DONE);
   assign arg_0_raddr_0 = (state_r == ST_RUN) ? elem_cnt_r[ADDR_WIDTH-1:0] : {ADDR_WIDTH{1'b0}};

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next;
      end
   end

   // Next-state logic; DRAIN ends once the last read has reached the RMW stage.
   always_comb begin
      state_next = state_r;
      case (state_r)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               if (clear_first) begin
                  state_next = ST_CLEAR;
               end else if (len == {(ADDR_WIDTH+1){1'b0}}) begin
                  state_next = ST_DONE;
               end else begin
                  state_next = ST_RUN;
               end
            end else begin
               state_next = state_r;
            end
         end
         ST_CLEAR: begin
            if (last_clear_s) begin
               state_next = (len_r == {(ADDR_WIDTH+1){1'b0}}) ? ST_DONE : ST_RUN;
            end else begin
               state_next = ST_CLEAR;
            end
         end
         ST_RUN: begin
            if (last_elem_s) begin
               state_next = ST_DRAIN;
            end else begin
               state_next = ST_RUN;
            end
         end
         ST_DRAIN: begin
            if (!elem_valid_r) begin
               state_next = ST_DONE;
            end else begin
               state_next = ST_DRAIN;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Run parameters, clear/element counters and the element-read valid flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         len_r        <= {(ADDR_WIDTH+1){1'b0}};
         elem_cnt_r   <= {(ADDR_WIDTH+1){1'b0}};
         clear_cnt_r  <= {BIN_ADDR_WIDTH{1'b0}};
         elem_valid_r <= 1'b0;
      end else begin
         elem_valid_r <= (state_r == ST_RUN);
         if (start_ok_s) begin
            len_r       <= len;
            elem_cnt_r  <= {(ADDR_WIDTH+1){1'b0}};
            clear_cnt_r <= {BIN_ADDR_WIDTH{1'b0}};
         end else if (state_r == ST_CLEAR) begin
            clear_cnt_r <= clear_cnt_r + {{(BIN_ADDR_WIDTH-1){1'b0}}, 1'b1};
         end else if (state_r == ST_RUN) begin
            elem_cnt_r  <= elem_cnt_r + {{ADDR_WIDTH{1'b0}}, 1'b1};
         end else begin
            elem_cnt_r  <= elem_cnt_r;
         end
      end
   end

   histogram_rmw_stage #(
      .DATA_WIDTH    (DATA_WIDTH),
      .BIN_ADDR_WIDTH(BIN_ADDR_WIDTH),
      .COUNT_WIDTH   (COUNT_WIDTH),
      .SATURATE      (SATURATE)
   ) u_rmw (
      .clk       (clk),
      .rst       (rst),
      .elem_valid(elem_valid_r),
      .element   (arg_0_rdata_0),
      .clear_en  (state_r == ST_CLEAR),
      .clear_addr(clear_cnt_r),
      .rdata     (arg_1_rdata_0),
      .raddr     (arg_1_raddr_0),
      .waddr     (arg_1_waddr_0),
      .wdata     (arg_1_wdata_0),
      .wen       (arg_1_wen_0),
      .wr_pending(wr_pending_s)
   );

   logic unused_s;
   assign unused_s = wr_pending_s;

endmodule

// File: tb/tb_histogram_engine.sv
// Self-checking bench for histogram_engine: write-port scoreboard, result RAM
// checks and handshake timing on a default instance plus two narrow instances.
module tb_histogram_engine;

   localparam int AW = 12;
   localparam int DW = 8;
   localparam int BW = 8;
   localparam int CW = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int wr_count = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- default instance ----------------
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [AW:0]   len = '0;
   logic          clear_first = 1'b0;
   logic          busy, valid;
   logic [AW-1:0] a0_raddr;
   logic [DW-1:0] a0_rdata;
   logic [BW-1:0] a1_raddr, a1_waddr;
   logic [CW-1:0] a1_rdata, a1_wdata;
   logic          a1_wen;

   logic [DW-1:0] mem0 [0:(1<<AW)-1];
   logic [CW-1:0] mem1 [0:(1<<BW)-1];
   logic [CW-1:0] model [0:(1<<BW)-1];
   logic          pre_en = 1'b0;
   logic [BW-1:0] pre_addr = '0;
   logic [CW-1:0] pre_data = '0;

   typedef struct packed {
      logic [BW-1:0] addr;
      logic [CW-1:0] data;
   } wr_t;
   wr_t exp_q[$];

   histogram_engine #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BIN_ADDR_WIDTH(BW),
                      .COUNT_WIDTH(CW), .SATURATE(0)) dut (
      .clk(clk), .rst(rst), .start(start), .len(len), .clear_first(clear_first),
      .busy(busy), .valid(valid),
      .arg_0_raddr_0(a0_raddr), .arg_0_rdata_0(a0_rdata),
      .arg_1_raddr_0(a1_raddr), .arg_1_rdata_0(a1_rdata),
      .arg_1_waddr_0(a1_waddr), .arg_1_wdata_0(a1_wdata), .arg_1_wen_0(a1_wen));

   always @(posedge clk) begin
      a0_rdata <= mem0[a0_raddr];
      a1_rdata <= mem1[a1_raddr];
      if (pre_en) mem1[pre_addr] <= pre_data;
      else if (a1_wen) mem1[a1_waddr] <= a1_wdata;
   end

   // Scoreboard: every write must match the next expected (addr, data).
   always @(negedge clk) begin
      if (a1_wen === 1'b1) begin
         wr_t e;
         checks++;
         wr_count++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: got addr %0d data %0d, required no write", a1_waddr, a1_wdata);
         end else begin
            e = exp_q.pop_front();
            if ({a1_waddr, a1_wdata} !== e) begin
               errors++;
               $display("FAIL write_seq: got addr %0d data %0d, required addr %0d data %0d",
                        a1_waddr, a1_wdata, e.addr, e.data);
            end
         end
      end
   end

   // ---------------- narrow instances: saturating and wrapping ----------------
   localparam int NAW = 5, NDW = 12, NBW = 4, NCW = 4;
   logic           start_n = 1'b0;
   logic [NAW:0]   len_n = '0;
   logic           clear_n = 1'b0;
   logic           busy_b, valid_b, busy_c, valid_c;
   logic [NAW-1:0] b0_raddr, c0_raddr;
   logic [NDW-1:0] b0_rdata, c0_rdata;
   logic [NBW-1:0] b1_raddr, b1_waddr, c1_raddr, c1_waddr;
   logic [NCW-1:0] b1_rdata, b1_wdata, c1_rdata, c1_wdata;
   logic           b1_wen, c1_wen;
   logic [NDW-1:0] mem0n [0:(1<<NAW)-1];
   logic [NCW-1:0] mem1b [0:(1<<NBW)-1];
   logic [NCW-1:0] mem1c [0:(1<<NBW)-1];

   histogram_engine #(.DATA_WIDTH(NDW), .ADDR_WIDTH(NAW), .BIN_ADDR_WIDTH(NBW),
                      .COUNT_WIDTH(NCW), .SATURATE(1)) dut_sat (
      .clk(clk), .rst(rst), .start(start_n), .len(len_n), .clear_first(clear_n),
      .busy(busy_b), .valid(valid_b),
      .arg_0_raddr_0(b0_raddr), .arg_0_rdata_0(b0_rdata),
      .arg_1_raddr_0(b1_raddr), .arg_1_rdata_0(b1_rdata),
      .arg_1_waddr_0(b1_waddr), .arg_1_wdata_0(b1_wdata), .arg_1_wen_0(b1_wen));

   histogram_engine #(.DATA_WIDTH(NDW), .ADDR_WIDTH(NAW), .BIN_ADDR_WIDTH(NBW),
                      .COUNT_WIDTH(NCW), .SATURATE(0)) dut_wrap (
      .clk(clk), .rst(rst), .start(start_n), .len(len_n), .clear_first(clear_n),
      .busy(busy_c), .valid(valid_c),
      .arg_0_raddr_0(c0_raddr), .arg_0_rdata_0(c0_rdata),
      .arg_1_raddr_0(c1_raddr), .arg_1_rdata_0(c1_rdata),
      .arg_1_waddr_0(c1_waddr), .arg_1_wdata_0(c1_wdata), .arg_1_wen_0(c1_wen));

   always @(posedge clk) begin
      b0_rdata <= mem0n[b0_raddr];
      c0_rdata <= mem0n[c0_raddr];
      b1_rdata <= mem1b[b1_raddr];
      c1_rdata <= mem1c[c1_raddr];
      if (b1_wen) mem1b[b1_waddr] <= b1_wdata;
      if (c1_wen) mem1c[c1_waddr] <= c1_wdata;
   end

   // ---------------- helpers ----------------
   function automatic void push_expect(input int n, input bit clr);
      int b;
      if (clr) begin
         for (int i = 0; i < (1 << BW); i++) begin
            model[i] = '0;
            exp_q.push_back('{addr: BW'(i), data: '0});
         end
      end
      for (int k = 0; k < n; k++) begin
         b = int'(mem0[k]) >> (DW - BW);
         model[b] = model[b] + 32'd1;
         exp_q.push_back('{addr: BW'(b), data: model[b]});
      end
   endfunction

   // Runs one job on the default instance; optionally pulses start mid-run.
   task automatic run_a(input int n, input bit clr, input int glitch, input string name);
      int c, t, exp_cyc;
      @(posedge clk); #1;
      push_expect(n, clr);
      wr_count = 0;
      c = cyc;
      start = 1'b1; len = (AW+1)'(n); clear_first = clr;
      @(posedge clk); #1;
      start = 1'b0; len = '0; clear_first = 1'b0;
      if (clr || n > 0) begin
         checks++;
         if (valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s_accept: got valid %b busy %b, required valid 0 busy 1", name, valid, busy);
         end
      end
      if (glitch > 0) begin
         repeat (glitch) @(posedge clk);
         #1; start = 1'b1; len = 13'd7; clear_first = 1'b1;
         @(posedge clk); #1; start = 1'b0; len = '0; clear_first = 1'b0;
      end
      exp_cyc = c + 1 + (clr ? (1 << BW) : 0) + ((n > 0) ? n + 2 : 0);
      t = 0;
      while (valid !== 1'b1 && t < 6000) begin
         @(negedge clk);
         t++;
      end
      checks++;
      if (valid !== 1'b1 || cyc != exp_cyc) begin
         errors++;
         $display("FAIL %s_done_time: got valid %b at cycle %0d, required valid 1 at cycle %0d",
                  name, valid, cyc, exp_cyc);
      end
      checks++;
      if (busy !== 1'b0 || exp_q.size() != 0 || wr_count != n + (clr ? (1 << BW) : 0)) begin
         errors++;
         $display("FAIL %s_drain: got busy %b pending %0d writes %0d, required busy 0 pending 0 writes %0d",
                  name, busy, exp_q.size(), wr_count, n + (clr ? (1 << BW) : 0));
      end
      @(posedge clk); #1;
      for (int i = 0; i < (1 << BW); i++) begin
         checks++;
         if (mem1[i] !== model[i]) begin
            errors++;
            $display("FAIL %s_bin%0d: got %0d, required %0d", name, i, mem1[i], model[i]);
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({busy, valid, a0_raddr, a1_raddr, a1_waddr, a1_wdata, a1_wen} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got busy %b valid %b a0 %0d a1r %0d a1w %0d wd %0d wen %b, required all 0",
                  busy, valid, a0_raddr, a1_raddr, a1_waddr, a1_wdata, a1_wen);
      end
      @(posedge clk); #1; rst = 1'b0;
   endtask

   task automatic test_clear();
      for (int i = 0; i < (1 << BW); i++) begin
         @(posedge clk); #1;
         pre_en = 1'b1; pre_addr = BW'(i); pre_data = $urandom;
         model[i] = pre_data;
      end
      @(posedge clk); #1; pre_en = 1'b0;
      run_a(0, 1'b1, 0, "clear_len0");
   endtask

   task automatic test_sequential();
      for (int k = 0; k < 100; k++) mem0[k] = DW'(k);
      run_a(100, 1'b0, 0, "seq100");
   endtask

   task automatic test_forwarding();
      logic [DW-1:0] pat [0:3];
      for (int k = 0; k < 16; k++) mem0[k] = 8'h2A;
      run_a(16, 1'b1, 0, "same_bin");
      checks++;
      if (mem1[42] !== 32'd16) begin
         errors++;
         $display("FAIL bin42_count: got %0d, required 16", mem1[42]);
      end
      pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h11; pat[3] = 8'h22;
      for (int k = 0; k < 4; k++) mem0[k] = pat[k];
      run_a(4, 1'b1, 0, "abab");
      checks++;
      if (mem1[8'h11] !== 32'd2 || mem1[8'h22] !== 32'd2) begin
         errors++;
         $display("FAIL abab_counts: got %0d/%0d, required 2/2", mem1[8'h11], mem1[8'h22]);
      end
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 50; k++) mem0[k] = DW'($urandom_range(0, 255));
      run_a(50, 1'b0, 10, "busy_start");
      for (int k = 0; k < 30; k++) mem0[k] = DW'($urandom_range(0, 7));
      run_a(30, 1'b0, 0, "start_in_done");
   endtask

   task automatic test_reset_midrun();
      int t;
      for (int k = 0; k < 100; k++) mem0[k] = DW'($urandom_range(0, 255));
      @(posedge clk); #1;
      push_expect(100, 1'b0);
      start = 1'b1; len = 13'd100;
      @(posedge clk); #1; start = 1'b0; len = '0;
      t = 0;
      while (!(busy === 1'b1 && a0_raddr == 12'd37) && t < 500) begin
         @(negedge clk);
         t++;
      end
      #2; rst = 1'b1;
      exp_q.delete();
      #1;
      checks++;
      if ({busy, valid, a0_raddr, a1_raddr, a1_waddr, a1_wdata, a1_wen} !== '0 || t >= 500) begin
         errors++;
         $display("FAIL midrun_reset: got busy %b valid %b a0 %0d a1r %0d wen %b (wait %0d), required all 0",
                  busy, valid, a0_raddr, a1_raddr, a1_wen, t);
      end
      @(posedge clk); #1; rst = 1'b0;
      repeat (8) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || valid !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_idle: got busy %b valid %b, required 0 0", busy, valid);
      end
      for (int k = 0; k < 10; k++) mem0[k] = DW'(200 + k);
      run_a(10, 1'b1, 0, "after_reset");
   endtask

   task automatic test_saturate();
      int hits [0:(1<<NBW)-1];
      int c, t, exp_cyc;
      logic [NCW-1:0] exp_sat, exp_wrap;
      for (int i = 0; i < (1 << NBW); i++) hits[i] = 0;
      for (int k = 0; k < 20; k++) mem0n[k] = 12'hFFF;
      mem0n[20] = 12'h123;
      mem0n[21] = 12'h7FF;
      for (int k = 0; k < 22; k++) hits[int'(mem0n[k]) >> (NDW - NBW)]++;
      @(posedge clk); #1;
      c = cyc;
      start_n = 1'b1; len_n = 6'd22; clear_n = 1'b1;
      @(posedge clk); #1; start_n = 1'b0; len_n = '0; clear_n = 1'b0;
      exp_cyc = c + 1 + (1 << NBW) + 22 + 2;
      t = 0;
      while (!(valid_b === 1'b1 && valid_c === 1'b1) && t < 1000) begin
         @(negedge clk);
         t++;
      end
      checks++;
      if (valid_b !== 1'b1 || valid_c !== 1'b1 || cyc != exp_cyc) begin
         errors++;
         $display("FAIL narrow_done_time: got valid %b/%b at cycle %0d, required 1/1 at cycle %0d",
                  valid_b, valid_c, cyc, exp_cyc);
      end
      @(posedge clk); #1;
      for (int i = 0; i < (1 << NBW); i++) begin
         exp_sat  = (hits[i] > 15) ? 4'd15 : NCW'(hits[i]);
         exp_wrap = NCW'(hits[i] % 16);
         checks++;
         if (mem1b[i] !== exp_sat || mem1c[i] !== exp_wrap) begin
            errors++;
            $display("FAIL narrow_bin%0d: got sat %0d wrap %0d, required sat %0d wrap %0d",
                     i, mem1b[i], mem1c[i], exp_sat, exp_wrap);
         end
      end
   endtask

   initial begin
      test_reset();
      test_clear();
      test_sequential();
      test_forwarding();
      test_back_to_back();
      test_reset_midrun();
      test_saturate();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
